// File: rtl/rng_pkg.sv
// Shared state encoding, default constants and LFSR step for the random-address requester.
package rng_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    CLEAR = 3'd3,
    OUT   = 3'd4
  } rng_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [16:0] TIMEOUT   = 17'd70000;

  // One Galois shift: feedback mask applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v, input logic [15:0] taps);
    return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
  endfunction

endpackage

// File: rtl/rng_lfsr16.sv
// 16-bit Galois LFSR; a zero seed is replaced by INIT so the register never locks at zero.
module rng_lfsr16
  import rng_pkg::*;
#(
  parameter logic [15:0] TAPS = 16'hB400,
  parameter logic [15:0] INIT = 16'hACE1
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      value <= INIT;
    end else if (load) begin
      value <= (seed == 16'h0000) ? INIT : seed;
    end else if (advance) begin
      value <= lfsr_step(value, TAPS);
    end
  end

endmodule

// File: rtl/rng_address_requester.sv
// Initiator for the start/done random-address handshake: draws an index, waits on the
// modulo responder with a timeout, re-arms it, and offers the result downstream.
module rng_address_requester #(
  parameter int          WIDTH     = 16,
  parameter logic [15:0] LFSR_TAPS = rng_pkg::LFSR_TAPS,
  parameter logic [15:0] LFSR_INIT = rng_pkg::LFSR_INIT,
  parameter logic [16:0] TIMEOUT   = rng_pkg::TIMEOUT
) (
  input  logic                clock,
  input  logic                nrst,
  input  logic                seed_load,
  input  logic [15:0]         seed,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [WIDTH-1:0]    count_in,
  output logic                start_rng_address,
  output logic [WIDTH-1:0]    which,
  output logic [WIDTH-1:0]    betterNeighborCount,
  input  logic [WIDTH-1:0]    rng_address,
  input  logic                done_rng_address,
  output logic                rng_clear_n,
  output logic                addr_valid,
  input  logic                addr_ready,
  output logic [WIDTH-1:0]    addr,
  output logic                err,
  output rng_pkg::rng_state_t state_dbg
);
  import rng_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid, once raised, holds with stable data until that transfer.

  localparam logic [16:0] TIMER_LAST = TIMEOUT - 17'd1;

  rng_state_t  state;
  logic [16:0] timer;
  logic [15:0] lfsr_value;
  logic        accept;
  logic        lfsr_load;
  logic        lfsr_adv;

  // A seed load in IDLE takes the cycle; the request is retried on the next one.
  assign accept    = (state == IDLE) && req_valid && !seed_load;
  assign lfsr_load = (state == IDLE) && seed_load;
  assign lfsr_adv  = accept && (count_in != '0);
  assign state_dbg = state;

  rng_lfsr16 #(
    .TAPS (LFSR_TAPS),
    .INIT (LFSR_INIT)
  ) u_lfsr (
    .clock   (clock),
    .nrst    (nrst),
    .load    (lfsr_load),
    .seed    (seed),
    .advance (lfsr_adv),
    .value   (lfsr_value)
  );

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state               <= IDLE;
      timer               <= '0;
      req_ready           <= 1'b1;
      start_rng_address   <= 1'b0;
      which               <= '0;
      betterNeighborCount <= '0;
      rng_clear_n         <= 1'b0;
      addr                <= '0;
      addr_valid          <= 1'b0;
      err                 <= 1'b0;
    end else begin
      start_rng_address <= 1'b0;
      rng_clear_n       <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (count_in == '0) begin
              // The responder would loop forever on a zero count, so never start it.
              addr       <= '0;
              err        <= 1'b1;
              addr_valid <= 1'b1;
              state      <= OUT;
            end else begin
              betterNeighborCount <= count_in;
              which               <= lfsr_step(lfsr_value, LFSR_TAPS);
              start_rng_address   <= 1'b1;
              state               <= START;
            end
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (done_rng_address) begin
            addr        <= rng_address;
            err         <= 1'b0;
            rng_clear_n <= 1'b0;
            state       <= CLEAR;
          end else if (timer == TIMER_LAST) begin
            addr        <= '0;
            err         <= 1'b1;
            rng_clear_n <= 1'b0;
            state       <= CLEAR;
          end else begin
            timer <= timer + 17'd1;
          end
        end
        CLEAR: begin
          addr_valid <= 1'b1;
          state      <= OUT;
        end
        OUT: begin
          if (addr_ready) begin
            addr_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_address_requester.sv
// Bench for rng_address_requester: behavioural modulo responder, LFSR/modulo reference
// model with an expected-result queue, directed corner cases plus randomized requests.
module tb_rng_address_requester;

  localparam logic [15:0] TAPS        = 16'hB400;
  localparam logic [15:0] INIT        = 16'hACE1;
  localparam int          TIMEOUT_CYC = 70000;

  logic        clock = 1'b0;
  logic        nrst = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] count_in = 16'h0;
  logic        start_rng_address;
  logic [15:0] which;
  logic [15:0] betterNeighborCount;
  logic [15:0] rng_address = 16'h0;
  logic        done_rng_address = 1'b0;
  logic        rng_clear_n;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic [15:0] addr;
  logic        err;
  logic [2:0]  state_dbg;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] model_lfsr = INIT;
  logic [16:0] exp_q[$];

  // responder model controls
  int          rsp_lat = 1;
  bit          rsp_hang = 1'b0;
  bit          rsp_busy = 1'b0;
  int          rsp_left = 0;
  logic [15:0] rsp_which = 16'h0;
  logic [15:0] rsp_cnt = 16'h1;

  rng_address_requester dut (
    .clock               (clock),
    .nrst                (nrst),
    .seed_load           (seed_load),
    .seed                (seed),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .count_in            (count_in),
    .start_rng_address   (start_rng_address),
    .which               (which),
    .betterNeighborCount (betterNeighborCount),
    .rng_address         (rng_address),
    .done_rng_address    (done_rng_address),
    .rng_clear_n         (rng_clear_n),
    .addr_valid          (addr_valid),
    .addr_ready          (addr_ready),
    .addr                (addr),
    .err                 (err),
    .state_dbg           (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- responder model ----------------
  always @(negedge clock or negedge nrst) begin
    if (!nrst) begin
      done_rng_address <= 1'b0;
      rsp_busy         <= 1'b0;
    end else if (!rng_clear_n) begin
      done_rng_address <= 1'b0;
      rsp_busy         <= 1'b0;
    end else if (start_rng_address) begin
      rsp_busy  <= 1'b1;
      rsp_left  <= rsp_lat;
      rsp_which <= which;
      rsp_cnt   <= betterNeighborCount;
    end else if (rsp_busy && !rsp_hang) begin
      if (rsp_left <= 1) begin
        done_rng_address <= 1'b1;
        rng_address      <= rsp_which % rsp_cnt;
        rsp_busy         <= 1'b0;
      end else begin
        rsp_left <= rsp_left - 1;
      end
    end
  end

  // ---------------- reference model / checking ----------------
  function automatic logic [15:0] lfsr_ref(input logic [15:0] x);
    if (x[0]) return (x >> 1) ^ TAPS;
    return x >> 1;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check_val("req_ready_idle", req_ready, 1);
  endtask

  task automatic do_seed(input logic [15:0] s, input bit collide);
    wait_idle();
    seed_load = 1'b1;
    seed      = s;
    if (collide) begin
      req_valid = 1'b1;
      count_in  = 16'd7;
    end
    @(negedge clock);
    seed_load = 1'b0;
    req_valid = 1'b0;
    seed      = 16'($urandom);
    model_lfsr = (s == 16'h0) ? INIT : s;
    if (collide) begin
      check_val("collide_not_taken", req_ready, 1);
      check_val("collide_no_start", start_rng_address, 0);
    end
  endtask

  // lat < 0 means the responder never answers.
  task automatic run_req(input logic [15:0] cnt, input int lat, input int hold);
    logic [15:0] exp_which;
    logic [15:0] exp_addr;
    logic [16:0] exp_item;
    int          starts, clears, waits, cyc;
    bit          seen_start;
    logic        prev_clear_n;
    logic [15:0] held_addr;
    logic        held_err;
    rsp_lat  = (lat < 1) ? 1 : lat;
    rsp_hang = (lat < 0);
    wait_idle();
    exp_which = 16'h0;
    if (cnt != 16'h0) begin
      model_lfsr = lfsr_ref(model_lfsr);
      exp_which  = model_lfsr;
      exp_addr   = (lat < 0) ? 16'h0 : exp_which % cnt;
      exp_q.push_back({(lat < 0), exp_addr});
    end else begin
      exp_q.push_back({1'b1, 16'h0});
    end
    req_valid = 1'b1;
    count_in  = cnt;
    @(negedge clock);
    req_valid = 1'b0;
    count_in  = 16'($urandom);
    starts = 0; clears = 0; waits = 0; cyc = 0;
    seen_start = 1'b0;
    prev_clear_n = 1'b1;
    while (!addr_valid && cyc < TIMEOUT_CYC + 200) begin
      if (start_rng_address) begin
        starts++;
        seen_start = 1'b1;
        check_val("which", which, exp_which);
        check_val("count_out", betterNeighborCount, cnt);
      end else if (seen_start && rng_clear_n) begin
        waits++;
      end
      if (!rng_clear_n) begin
        clears++;
        check_val("which_hold", which, exp_which);
        check_val("count_hold", betterNeighborCount, cnt);
      end
      prev_clear_n = rng_clear_n;
      @(negedge clock);
      cyc++;
    end
    check_val("addr_valid_seen", addr_valid, 1);
    check_val("start_pulses", starts, (cnt != 16'h0) ? 1 : 0);
    check_val("clear_pulses", clears, (cnt != 16'h0) ? 1 : 0);
    check_val("clear_before_valid", prev_clear_n, (cnt == 16'h0) ? 1 : 0);
    if (cnt == 16'h0) check_val("zero_fast", (cyc <= 1), 1);
    if (lat < 0 && cnt != 16'h0) check_val("timeout_cycles", waits, TIMEOUT_CYC);
    check_val("sb_nonempty", (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      exp_item = exp_q.pop_front();
      check_val("addr", addr, exp_item[15:0]);
      check_val("err", err, exp_item[16]);
    end
    held_addr = addr;
    held_err  = err;
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      check_val("hold_valid", addr_valid, 1);
      check_val("hold_addr", addr, held_addr);
      check_val("hold_err", err, held_err);
      check_val("hold_req_ready", req_ready, 0);
    end
    addr_ready = 1'b1;
    @(negedge clock);
    addr_ready = 1'b0;
    check_val("valid_dropped", addr_valid, 0);
    check_val("back_to_idle", req_ready, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #50000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] c;
    int          r;
    #3 nrst = 1'b0;
    #1;
    check_val("rst_start", start_rng_address, 0);
    check_val("rst_which", which, 0);
    check_val("rst_count", betterNeighborCount, 0);
    check_val("rst_addr", addr, 0);
    check_val("rst_valid", addr_valid, 0);
    check_val("rst_err", err, 0);
    check_val("rst_clear_n", rng_clear_n, 0);
    repeat (2) @(negedge clock);
    nrst = 1'b1;
    @(negedge clock);
    check_val("clear_n_after_rst", rng_clear_n, 1);
    check_val("ready_after_rst", req_ready, 1);

    // seed 1 with a colliding request, then the directed sequence
    do_seed(16'h0001, 1'b1);
    run_req(16'd7, 2, 0);
    run_req(16'hFFFF, 3, 1);
    run_req(16'h0000, 1, 0);
    run_req(16'd3, 1, 0);

    // randomized requests, occasional reseeding (including zero)
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 4) == 0)
        do_seed(($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom), 1'b0);
      r = $urandom_range(0, 3);
      case (r)
        0:       c = 16'h0;
        1:       c = 16'($urandom_range(1, 10));
        2:       c = 16'($urandom);
        default: c = 16'hFFFF;
      endcase
      run_req(c, $urandom_range(1, 6), $urandom_range(0, 3));
    end

    // downstream back-pressure
    run_req(16'd100, 3, 10);

    // responder never answers
    run_req(16'd9, -1, 2);

    // reset in the middle of WAIT
    rsp_hang = 1'b1;
    wait_idle();
    req_valid = 1'b1;
    count_in  = 16'd5;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (6) @(negedge clock);
    #2 nrst = 1'b0;
    #1;
    check_val("abort_start", start_rng_address, 0);
    check_val("abort_which", which, 0);
    check_val("abort_count", betterNeighborCount, 0);
    check_val("abort_addr", addr, 0);
    check_val("abort_valid", addr_valid, 0);
    check_val("abort_err", err, 0);
    check_val("abort_clear_n", rng_clear_n, 0);
    check_val("abort_ready", req_ready, 1);
    model_lfsr = INIT;
    repeat (2) @(negedge clock);
    nrst = 1'b1;
    @(negedge clock);
    check_val("clear_n_after_abort", rng_clear_n, 1);
    check_val("no_stale_valid", addr_valid, 0);
    run_req(16'd1000, 2, 0);

    check_val("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rng_address_requester.md
Name: rng_address_requester

Overview:
- Initiator side of the random-address handshake (start_rng_address / done_rng_address).
- Accepts a request carrying a neighbor count and draws a 16-bit pseudo-random index from an internal LFSR.
- Drives the modulo responder, captures the reduced address, and re-arms the responder, which otherwise holds done high forever.
- Guards the responder's count==0 infinite loop and hangs via a timeout, then hands the address downstream over valid/ready.

Parameters:
- WIDTH, 16, data width of index, count and address.
- LFSR_TAPS, 16'hB400, Galois LFSR feedback mask.
- LFSR_INIT, 16'hACE1, LFSR reset value; also substituted whenever a zero seed is loaded.
- TIMEOUT, 17'd70000, maximum WAIT cycles before abort. Exceeds worst-case responder latency of 65537.

Ports:
- clock  in  1  single clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- seed_load  in  1  load seed into LFSR; honoured only in IDLE.
- seed  in  16  LFSR seed value.
- req_valid  in  1  request strobe.
- req_ready  out  1  high in IDLE.
- count_in  in  16  neighbor count for the request.
- start_rng_address  out  1  one-cycle start pulse to the responder.
- which  out  16  random index presented to the responder.
- betterNeighborCount  out  16  latched count presented to the responder.
- rng_address  in  16  responder result.
- done_rng_address  in  1  responder done; sticky until the responder is cleared.
- rng_clear_n  out  1  synchronous active-low clear for the responder's nrst.
- addr_valid  out  1  result valid.
- addr_ready  in  1  downstream accept.
- addr  out  16  reduced address.
- err  out  1  qualifies addr_valid; 1 means count==0 or timeout, and addr=0.

Behaviour:
- All outputs are registered.
- Values while nrst is low:
  - state=IDLE, LFSR=LFSR_INIT, timer=0.
  - start_rng_address=0, which=0, betterNeighborCount=0, addr=0, addr_valid=0, err=0.
  - rng_clear_n=0, so the responder is held in reset.
- First clock after reset release: rng_clear_n=1.
- LFSR advance rule: if lfsr[0], next = (lfsr>>1)^LFSR_TAPS; otherwise next = lfsr>>1. It advances only on an accepted request.
- IDLE:
  - req_ready=1.
  - seed_load loads seed, or LFSR_INIT if seed==0.
  - If req_valid and seed_load arrive in the same cycle, the seed load wins and the request is not accepted that cycle.
  - req_valid&&req_ready with count_in==0 → OUT with addr=0, err=1. No start is issued and the LFSR does not advance.
  - req_valid&&req_ready with count_in!=0 → betterNeighborCount=count_in, LFSR advances, which=next value, go to START.
- START:
  - start_rng_address=1 for exactly one cycle, then WAIT.
  - timer cleared.
- WAIT:
  - timer increments each cycle.
  - done_rng_address=1 → addr=rng_address, err=0, go to CLEAR.
  - timer==TIMEOUT-1 without done → addr=0, err=1, go to CLEAR.
  - If done and timeout coincide, done wins.
- CLEAR:
  - rng_clear_n=0 for exactly one cycle, then OUT.
- which and betterNeighborCount are held stable from START through the end of CLEAR, because the responder re-reads the count every iteration.
- OUT:
  - addr_valid=1; addr and err are held.
  - addr_ready → addr_valid=0 and return to IDLE. No new request is accepted in that same cycle.
- Asserting nrst at any time, including mid-WAIT, aborts the operation. All reset values apply, and the result is not delivered.
- Back-to-back requests take a minimum of 5 cycles plus responder latency.

Decomposition:
- Shared package rng_pkg:
  - state encoding: IDLE, START, WAIT, CLEAR, OUT (3 bits).
  - constants LFSR_TAPS, LFSR_INIT, TIMEOUT.
- One sub-module, rng_lfsr16:
  - inputs: clock, nrst, load, seed, advance.
  - output: value.
  - Galois LFSR with the zero-seed substitution.

Test Plan:
- seed_load with seed=16'h0001, then request count_in=7 → which=16'hB400, one start pulse, addr=6, err=0, then one rng_clear_n low cycle before addr_valid.
- Next request with count_in=16'hFFFF → which=16'h5A00, addr=16'h5A00, err=0. This is the count > which case, with zero subtractions.
- Request with count_in=0 → addr_valid with addr=0, err=1 within 2 cycles. start_rng_address is never asserted and the LFSR does not advance.
- Responder model holds done low → err=1, addr=0 after exactly TIMEOUT WAIT cycles, followed by a clear pulse.
- addr_ready held low for 10 cycles → addr and err stay stable and req_ready stays 0. Asserting addr_ready returns the block to IDLE.
- Assert nrst mid-WAIT → all outputs take reset values asynchronously and rng_clear_n=0. After release, a request with seed 16'hACE1 retained completes normally.
